// File: rtl/dd2_sub_pkg.sv
// dd2_sub_pkg: address-region codes and default read value for the DD2 sub-CPU glue
package dd2_sub_pkg;
  localparam logic [1:0] ROM_TOP = 2'b11;
  localparam logic [1:0] SH      = 2'h0;
  localparam logic [1:0] NMIACK  = 2'h1;
  localparam logic [1:0] IRQMAIN = 2'h2;
  localparam logic [7:0] DEF_DIN = 8'hFF;
endpackage

// File: rtl/dd2_sub_glue_if.sv
// dd2_sub_glue_if: sub-Z80, main-CPU and ROM-port signals of the DD2 sub-CPU glue
interface dd2_sub_glue_if #(parameter int AW = 10);
  logic          cen4;
  logic          cen_cpu;
  logic [15:0]   cpu_addr;
  logic          cpu_mreq_n;
  logic          cpu_wr_n;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_nmi_n;
  logic          cpu_busak_n;
  logic          cpu_busrq_n;
  logic [AW-1:0] main_addr;
  logic          main_wrn;
  logic [7:0]    main_dout;
  logic          com_cs;
  logic [7:0]    shared_dout;
  logic          mcu_halt;
  logic          mcu_nmi_set;
  logic          mcu_ban;
  logic          mcu_irqmain;
  logic [15:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          rom_cs;
  logic          rom_ok;
  modport master (
    output cen4, cpu_addr, cpu_mreq_n, cpu_wr_n, cpu_dout, cpu_busak_n,
           main_addr, main_wrn, main_dout, com_cs, mcu_halt, mcu_nmi_set, rom_data, rom_ok,
    input  cen_cpu, cpu_din, cpu_nmi_n, cpu_busrq_n, shared_dout, mcu_ban, mcu_irqmain, rom_addr, rom_cs
  );
  modport slave (
    input  cen4, cpu_addr, cpu_mreq_n, cpu_wr_n, cpu_dout, cpu_busak_n,
           main_addr, main_wrn, main_dout, com_cs, mcu_halt, mcu_nmi_set, rom_data, rom_ok,
    output cen_cpu, cpu_din, cpu_nmi_n, cpu_busrq_n, shared_dout, mcu_ban, mcu_irqmain, rom_addr, rom_cs
  );
endinterface

// File: rtl/dd2_sub_dpram.sv
// dd2_sub_dpram: true dual-port 2**AW x 8 RAM, registered reads returning old data, port A wins same-address writes
module dd2_sub_dpram #(parameter int AW = 10) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_a,
  input  logic          we_a,
  input  logic [7:0]    d_a,
  output logic [7:0]    q_a,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  input  logic [7:0]    d_b,
  output logic [7:0]    q_b
);
  logic [7:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= d_b;
    if (we_a) mem[addr_a] <= d_a;
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end
  end
endmodule

// File: rtl/dd2_sub_glue.sv
// dd2_sub_glue: DD2 sub-Z80 bus glue (decode, NMI latch, ROM-wait gating, read mux, shared RAM); DD2_SUB_TRACE_EN adds sim trace
module dd2_sub_glue
  import dd2_sub_pkg::*;
#(parameter int AW = 10) (
  input logic           clk,
  input logic           rst,
  dd2_sub_glue_if.slave bus
);
  logic       hi, shared_cs, nmi_ack, set_q, nmi_q, nmi_d;
  logic [7:0] q_a;
  assign hi               = ~bus.cpu_mreq_n & (bus.cpu_addr[15:14] == ROM_TOP);
  assign bus.rom_cs       = ~bus.cpu_mreq_n & (bus.cpu_addr[15:14] != ROM_TOP);
  assign shared_cs        = hi & (bus.cpu_addr[13:12] == SH);
  assign nmi_ack          = hi & (bus.cpu_addr[13:12] == NMIACK) & ~bus.cpu_wr_n;
  assign bus.mcu_irqmain  = hi & (bus.cpu_addr[13:12] == IRQMAIN) & ~bus.cpu_wr_n;
  assign bus.cpu_din      = bus.rom_cs ? bus.rom_data : shared_cs ? q_a : DEF_DIN;
  assign bus.cen_cpu      = bus.cen4 & ~(bus.rom_cs & ~bus.rom_ok);
  assign bus.rom_addr     = bus.cpu_addr;
  assign bus.cpu_busrq_n  = bus.mcu_halt;
  assign bus.mcu_ban      = bus.cpu_busak_n;
  assign bus.cpu_nmi_n    = ~nmi_q;
  assign nmi_d            = (bus.mcu_nmi_set & ~set_q) | (nmi_q & ~nmi_ack);
  always_ff @(posedge clk) begin
    if (rst) begin
      set_q <= 1'b0;
      nmi_q <= 1'b0;
    end else begin
      set_q <= bus.mcu_nmi_set;
      nmi_q <= nmi_d;
    end
  end
  dd2_sub_dpram #(.AW(AW)) u_ram (
    .clk    (clk),
    .rst    (rst),
    .addr_a (bus.cpu_addr[AW-1:0]),
    .we_a   (shared_cs & ~bus.cpu_wr_n),
    .d_a    (bus.cpu_dout),
    .q_a    (q_a),
    .addr_b (bus.main_addr),
    .we_b   (~bus.main_wrn & bus.com_cs & ~bus.cpu_busak_n),
    .d_b    (bus.main_dout),
    .q_b    (bus.shared_dout)
  );
`ifdef DD2_SUB_TRACE_EN
  logic halt_t, nset_t;
  always @(posedge clk) begin
    halt_t <= bus.mcu_halt;
    nset_t <= bus.mcu_nmi_set;
    if (bus.mcu_halt & ~halt_t) $display("dd2_sub: mcu_halt rise @%0t", $time);
    if (~bus.mcu_halt & halt_t) $display("dd2_sub: mcu_halt fall @%0t", $time);
    if (bus.mcu_nmi_set & ~nset_t) $display("dd2_sub: mcu_nmi_set rise @%0t", $time);
  end
`endif
endmodule

// File: tb/tb_dd2_sub_glue.sv
// tb_dd2_sub_glue: scoreboard bench for dd2_sub_glue against a range-based behavioural model
module tb_dd2_sub_glue;
  typedef struct packed {
    logic rst, cen4;
    logic [15:0] addr;
    logic mreq_n, wr_n;
    logic [7:0] dout;
    logic busak_n;
    logic [9:0] maddr;
    logic mwrn;
    logic [7:0] mdout;
    logic com_cs, halt, nset;
    logic [7:0] rdata;
    logic rok;
  } stim_t;
  typedef struct packed {
    logic cen, nmi_n, busrq_n, ban, irq, rom_cs, din_chk, sd_chk;
    logic [7:0] din, sd;
    logic [15:0] raddr;
  } exp_t;
  logic clk = 0;
  logic rst;
  int total = 0, bad = 0;
  exp_t sb[$];
  stim_t cur;
  logic [7:0] mem [1024];
  bit val [1024];
  bit nmi = 0, prev = 0, qa_v = 0, qb_v = 0;
  logic [7:0] qa = 0, qb = 0;
  dd2_sub_glue_if #(.AW(10)) bus ();
  dd2_sub_glue #(.AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic stim_t idle();
    stim_t s = '0;
    s.cen4 = 1; s.mreq_n = 1; s.wr_n = 1; s.busak_n = 1; s.mwrn = 1; s.halt = 1; s.rok = 1;
    return s;
  endfunction
  task automatic apply(input stim_t s);
    rst = s.rst; bus.cen4 = s.cen4; bus.cpu_addr = s.addr; bus.cpu_mreq_n = s.mreq_n;
    bus.cpu_wr_n = s.wr_n; bus.cpu_dout = s.dout; bus.cpu_busak_n = s.busak_n;
    bus.main_addr = s.maddr; bus.main_wrn = s.mwrn; bus.main_dout = s.mdout; bus.com_cs = s.com_cs;
    bus.mcu_halt = s.halt; bus.mcu_nmi_set = s.nset; bus.rom_data = s.rdata; bus.rom_ok = s.rok;
  endtask
  function automatic bit in_rng(stim_t s, logic [15:0] lo, logic [15:0] hi);
    return !s.mreq_n && s.addr >= lo && s.addr <= hi;
  endfunction
  task automatic update(input stim_t s);
    logic [9:0] a;
    a = s.addr[9:0];
    if (s.rst) begin
      qa = 0; qb = 0; qa_v = 1; qb_v = 1; nmi = 0; prev = 0;
    end else begin
      qa = mem[a]; qa_v = val[a]; qb = mem[s.maddr]; qb_v = val[s.maddr];
      if (s.nset && !prev) nmi = 1;
      else if (in_rng(s, 16'hD000, 16'hDFFF) && !s.wr_n) nmi = 0;
      prev = s.nset;
    end
    if (!s.mwrn && s.com_cs && !s.busak_n) begin mem[s.maddr] = s.mdout; val[s.maddr] = 1; end
    if (in_rng(s, 16'hC000, 16'hCFFF) && !s.wr_n) begin mem[a] = s.dout; val[a] = 1; end
  endtask
  function automatic exp_t expect_of(stim_t s);
    exp_t e;
    bit rom, sh;
    rom = in_rng(s, 16'h0000, 16'hBFFF);
    sh = in_rng(s, 16'hC000, 16'hCFFF);
    e.rom_cs = rom;
    e.irq = in_rng(s, 16'hE000, 16'hEFFF) && !s.wr_n;
    e.din = rom ? s.rdata : sh ? qa : 8'hFF;
    e.din_chk = !(sh && !rom && !qa_v);
    e.cen = s.cen4 && !(rom && !s.rok);
    e.nmi_n = !nmi;
    e.sd = qb;
    e.sd_chk = qb_v;
    e.busrq_n = s.halt;
    e.ban = s.busak_n;
    e.raddr = s.addr;
    return e;
  endfunction
  task automatic step(input stim_t n);
    @(posedge clk);
    update(cur);
    #1;
    cur = n;
    apply(n);
    sb.push_back(expect_of(n));
  endtask
  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk("cen_cpu", 16'(bus.cen_cpu), 16'(e.cen));
      chk("cpu_nmi_n", 16'(bus.cpu_nmi_n), 16'(e.nmi_n));
      chk("cpu_busrq_n", 16'(bus.cpu_busrq_n), 16'(e.busrq_n));
      chk("mcu_ban", 16'(bus.mcu_ban), 16'(e.ban));
      chk("mcu_irqmain", 16'(bus.mcu_irqmain), 16'(e.irq));
      chk("rom_cs", 16'(bus.rom_cs), 16'(e.rom_cs));
      chk("rom_addr", bus.rom_addr, e.raddr);
      if (e.din_chk) chk("cpu_din", 16'(bus.cpu_din), 16'(e.din));
      if (e.sd_chk) chk("shared_dout", 16'(bus.shared_dout), 16'(e.sd));
    end
  end
  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1;
    apply(cur);
    s = idle(); s.rst = 1;
    step(s); step(s);
    s = idle(); s.addr = 16'hC005; s.mreq_n = 0; s.wr_n = 0; s.dout = 8'h5A; step(s);
    s = idle(); s.busak_n = 0; s.com_cs = 1; s.maddr = 10'h005; step(s); step(s);
    s = idle(); s.maddr = 10'h010; s.mwrn = 0; s.com_cs = 1; s.mdout = 8'hA5; step(s);
    s = idle(); s.addr = 16'hC010; s.mreq_n = 0; step(s); step(s);
    s = idle(); s.maddr = 10'h010; s.mwrn = 0; s.com_cs = 1; s.mdout = 8'hA5; s.busak_n = 0; step(s);
    s = idle(); s.addr = 16'hC010; s.mreq_n = 0; step(s); step(s);
    s = idle(); s.nset = 1; step(s); step(s); step(s);
    s.addr = 16'hD000; s.mreq_n = 0; s.wr_n = 0; step(s);
    s = idle(); s.nset = 1; step(s); step(s); step(s);
    s = idle(); s.addr = 16'h1234; s.mreq_n = 0; s.rok = 0; step(s);
    s.rok = 1; s.rdata = 8'h3C; step(s);
    s.cen4 = 0; step(s);
    s = idle(); s.addr = 16'hE000; s.mreq_n = 0; s.wr_n = 0; step(s);
    s.mreq_n = 1; step(s);
    s = idle(); s.addr = 16'hF000; s.mreq_n = 0; step(s);
    s = idle(); step(s);
    s.nset = 1; step(s); step(s);
    s.rst = 1; step(s); step(s);
    s = idle(); step(s);
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(63) == 0);
      s.cen4 = 1'($urandom);
      s.addr = 16'($urandom) & 16'hFC1F;
      s.mreq_n = ($urandom_range(3) == 0);
      s.wr_n = 1'($urandom);
      s.dout = 8'($urandom);
      s.busak_n = 1'($urandom);
      s.maddr = 10'($urandom_range(31));
      s.mwrn = 1'($urandom);
      s.mdout = 8'($urandom);
      s.com_cs = 1'($urandom);
      s.halt = 1'($urandom);
      if ($urandom_range(5) == 0) s.nset = ~s.nset;
      s.rdata = 8'($urandom);
      s.rok = ($urandom_range(3) != 0);
      step(s);
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
